// File: rtl/mem_store.sv
// Byte-serial store engine: writes an sb/sh/sw request over the 8-bit memory bus,
// one little-endian byte per granted cycle, with busy stall and a one-cycle done pulse.
module mem_store #(
    parameter int unsigned AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_data,
    input  logic [1:0]    i_size,
    input  logic          i_gnt,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_mem_a,
    output logic [7:0]    o_mem_wn,
    output logic          o_mem_wr
);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_t;

    state_t        r_state, w_state_d;
    logic [AW-1:0] r_base, w_base_d;
    logic [31:0]   r_buf, w_buf_d;
    logic [1:0]    r_idx, w_idx_d;
    logic [1:0]    r_last, w_last_d;
    logic [AW-1:0] r_mem_a, w_mem_a_d;
    logic [7:0]    r_mem_wn, w_mem_wn_d;
    logic          r_busy, r_done, r_mem_wr;
    logic [1:0]    w_idx_inc;

    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    assign w_idx_inc = r_idx + 2'd1;

    always_comb begin
        w_state_d  = r_state;
        w_base_d   = r_base;
        w_buf_d    = r_buf;
        w_idx_d    = r_idx;
        w_last_d   = r_last;
        w_mem_a_d  = r_mem_a;
        w_mem_wn_d = r_mem_wn;
        case (r_state)
            StIdle, StDone: begin
                if (i_req) begin
                    w_state_d  = StWrite;
                    w_base_d   = i_addr;
                    w_buf_d    = i_data;
                    w_idx_d    = 2'd0;
                    w_last_d   = (i_size == 2'd0) ? 2'd0 : (i_size == 2'd1) ? 2'd1 : 2'd3;
                    w_mem_a_d  = i_addr;
                    w_mem_wn_d = i_data[7:0];
                end else if (r_state == StDone) begin
                    w_state_d = StIdle;
                end
            end
            StWrite: begin
                // Without a grant the whole bus word is frozen.
                if (i_gnt) begin
                    if (r_idx == r_last) begin
                        w_state_d = StDone;
                    end else begin
                        w_idx_d    = w_idx_inc;
                        w_mem_a_d  = r_base + {{(AW-2){1'b0}}, w_idx_inc};
                        w_mem_wn_d = sel_byte(r_buf, w_idx_inc);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_base   <= '0;
            r_buf    <= '0;
            r_idx    <= '0;
            r_last   <= '0;
            r_mem_a  <= '0;
            r_mem_wn <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mem_wr <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_base   <= w_base_d;
            r_buf    <= w_buf_d;
            r_idx    <= w_idx_d;
            r_last   <= w_last_d;
            r_mem_a  <= w_mem_a_d;
            r_mem_wn <= w_mem_wn_d;
            r_busy   <= (w_state_d == StWrite);
            r_done   <= (w_state_d == StDone);
            r_mem_wr <= (w_state_d == StWrite);
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_mem_a  = r_mem_a;
    assign o_mem_wn = r_mem_wn;
    assign o_mem_wr = r_mem_wr;

endmodule

// File: tb/tb_mem_store.sv
// Directed bench for mem_store: reset, sb/sh/sw stores, grant stalls with address wrap,
// back-to-back stores, ignored req and reset mid-store.
module tb_mem_store;

    logic        clk = 1'b0;
    logic        rst, req, gnt;
    logic [31:0] addr, data;
    logic [1:0]  size;
    logic        busy, done, mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_wn;

    int n_total = 0;
    int n_bad   = 0;
    int wr_cnt  = 0;
    int wr_base;

    always #5 clk = ~clk;

    mem_store #(.AW(32)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_addr  (addr),
        .i_data  (data),
        .i_size  (size),
        .i_gnt   (gnt),
        .o_busy  (busy),
        .o_done  (done),
        .o_mem_a (mem_a),
        .o_mem_wn(mem_wn),
        .o_mem_wr(mem_wr)
    );

    // Bytes actually committed to memory
    always @(posedge clk) if (mem_wr && gnt) wr_cnt <= wr_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [31:0] a, input logic [7:0] wn,
                             input logic wr, input logic bsy, input logic dn);
        if (wr) begin
            check_eq({tag, ".mem_a"}, mem_a, a);
            check_eq({tag, ".mem_wn"}, {24'h0, mem_wn}, {24'h0, wn});
        end
        check_eq({tag, ".mem_wr"}, {31'h0, mem_wr}, {31'h0, wr});
        check_eq({tag, ".busy"}, {31'h0, busy}, {31'h0, bsy});
        check_eq({tag, ".done"}, {31'h0, done}, {31'h0, dn});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b1; gnt = 1'b1;
        addr = 32'h100; data = 32'hDDCCBBAA; size = 2'd2;
        step(); step();
        check_eq("rst.mem_a", mem_a, 32'h0);
        check_eq("rst.mem_wn", {24'h0, mem_wn}, 32'h0);
        check_bus("rst", 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Word store, req held through reset release
        wr_base = wr_cnt;
        rst = 1'b0;
        step(); req = 1'b0;
        check_bus("w.c1", 32'h100, 8'hAA, 1'b1, 1'b1, 1'b0);
        step(); check_bus("w.c2", 32'h101, 8'hBB, 1'b1, 1'b1, 1'b0);
        step(); check_bus("w.c3", 32'h102, 8'hCC, 1'b1, 1'b1, 1'b0);
        step(); check_bus("w.c4", 32'h103, 8'hDD, 1'b1, 1'b1, 1'b0);
        step(); check_bus("w.c5", 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        check_eq("w.writes", 32'(wr_cnt - wr_base), 32'd4);
        step(); check_bus("w.c6", 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Byte store
        req = 1'b1; addr = 32'h7; data = 32'h12345678; size = 2'd0;
        step(); req = 1'b0;
        check_bus("b.c1", 32'h7, 8'h78, 1'b1, 1'b1, 1'b0);
        step(); check_bus("b.c2", 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        step(); check_bus("b.c3", 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Half store, misaligned
        req = 1'b1; addr = 32'h21; size = 2'd1;
        step(); req = 1'b0;
        check_bus("h.c1", 32'h21, 8'h78, 1'b1, 1'b1, 1'b0);
        step(); check_bus("h.c2", 32'h22, 8'h56, 1'b1, 1'b1, 1'b0);
        step(); check_bus("h.c3", 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        step(); check_bus("h.c4", 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Word store with grant stall and address wrap
        wr_base = wr_cnt;
        req = 1'b1; addr = 32'hFFFFFFFE; data = 32'h44332211; size = 2'd2;
        step(); req = 1'b0;
        check_bus("s.c1", 32'hFFFFFFFE, 8'h11, 1'b1, 1'b1, 1'b0);
        step(); check_bus("s.c2", 32'hFFFFFFFF, 8'h22, 1'b1, 1'b1, 1'b0);
        gnt = 1'b0;
        step(); check_bus("s.c3", 32'hFFFFFFFF, 8'h22, 1'b1, 1'b1, 1'b0);
        step(); check_bus("s.c4", 32'hFFFFFFFF, 8'h22, 1'b1, 1'b1, 1'b0);
        check_eq("s.stall_writes", 32'(wr_cnt - wr_base), 32'd1);
        gnt = 1'b1;
        step(); check_bus("s.c5", 32'h0, 8'h33, 1'b1, 1'b1, 1'b0);
        step(); check_bus("s.c6", 32'h1, 8'h44, 1'b1, 1'b1, 1'b0);
        step(); check_bus("s.c7", 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        check_eq("s.writes", 32'(wr_cnt - wr_base), 32'd4);
        step();

        // Ignored req mid-store, then back-to-back store from DONE
        req = 1'b1; addr = 32'h200; data = 32'hA1B2C3D4; size = 2'd2;
        step(); req = 1'b0;
        check_bus("k.c1", 32'h200, 8'hD4, 1'b1, 1'b1, 1'b0);
        step(); check_bus("k.c2", 32'h201, 8'hC3, 1'b1, 1'b1, 1'b0);
        req = 1'b1; addr = 32'h300; data = 32'h55555555; size = 2'd0;
        step(); req = 1'b0;
        check_bus("k.c3", 32'h202, 8'hB2, 1'b1, 1'b1, 1'b0);
        step(); check_bus("k.c4", 32'h203, 8'hA1, 1'b1, 1'b1, 1'b0);
        step(); check_bus("k.c5", 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        req = 1'b1; addr = 32'h40; data = 32'h000000EE; size = 2'd0;
        step(); req = 1'b0;
        check_bus("k.c6", 32'h40, 8'hEE, 1'b1, 1'b1, 1'b0);
        step(); check_bus("k.c7", 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        step(); check_bus("k.c8", 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Reset in cycle 2 of a word store
        wr_base = wr_cnt;
        req = 1'b1; addr = 32'h500; data = 32'h87654321; size = 2'd2;
        step(); req = 1'b0;
        check_bus("r.c1", 32'h500, 8'h21, 1'b1, 1'b1, 1'b0);
        step(); check_bus("r.c2", 32'h501, 8'h43, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step(); rst = 1'b0;
        check_bus("r.c3", 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        check_eq("r.mem_a", mem_a, 32'h0);
        step(); check_bus("r.c4", 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        step(); check_bus("r.c5", 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        check_eq("r.writes", 32'(wr_cnt - wr_base), 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_store.md
# mem_store

Byte-serial store engine for the core's memory stage. It accepts one store request (sb/sh/sw) and writes it over the 8-bit memory bus that the fetch unit reads through, as one byte per granted cycle in little-endian order. It stalls the pipeline via `busy` and reports completion with a one-cycle `done` pulse. The bus arbiter in the top level muxes its address, data and write-enable onto the memory port while it holds `gnt`.

## Interface
Parameters:
- `AW`, 32, address width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  1  store request. Sampled only in IDLE or DONE.
- `addr`  in  AW  byte address of the store. Any alignment is allowed.
- `data`  in  32  store data; byte 0 is `data[7:0]`.
- `size`  in  2  0 = byte, 1 = half, 2 = word, 3 = word.
- `gnt`  in  1  bus grant from the arbiter. A byte retires only on a clock edge where `gnt`=1.
- `busy`  out  1  store in progress; the pipeline holds the memory stage.
- `done`  out  1  one-cycle pulse after the last byte retires.
- `mem_a`  out  AW  byte address on the bus.
- `mem_wn`  out  8  write data byte.
- `mem_wr`  out  1  write strobe. Memory writes on a clock edge only where `mem_wr`=1 and `gnt`=1.

## Operation
State machine: IDLE, WRITE, DONE. All outputs are registered.

Registers:
- `base` (AW): latched `addr`.
- `buf` (32): latched `data`.
- `idx` (2): current byte index.
- `last` (2): final byte index, set to `size` mapped as 0→0, 1→1, 2/3→3.

IDLE:
- `busy`=0, `done`=0, `mem_wr`=0.
- On `req`=1: latch `base`, `buf`, `last`; set `idx`=0; go to WRITE.

WRITE:
- `busy`=1, `mem_wr`=1, `mem_a`=`base`+`idx`, `mem_wn`=`buf[8*idx+7 : 8*idx]`.
- Address addition is mod 2^AW; it wraps with no error.
- On an edge with `gnt`=1 and `idx`!=`last`: `idx` increments.
- On an edge with `gnt`=1 and `idx`==`last`: go to DONE.
- On an edge with `gnt`=0: hold all outputs and registers unchanged.

DONE:
- `done`=1, `busy`=0, `mem_wr`=0.
- On `req`=1: accept the new store as in IDLE and go to WRITE (back-to-back stores).
- Otherwise: go to IDLE.

Other rules:
- `req` in WRITE is ignored. It is not queued; the pipeline must hold `req` until it sees `busy`=0.
- `mem_a` and `mem_wn` in IDLE/DONE hold their last driven values. They are don't-care, because `mem_wr`=0.
- No alignment checks are made, and a misaligned halfword or word is written as consecutive bytes.
- `rst`=1 at any edge:
  - state goes to IDLE; `busy`, `done`, `mem_wr`, `mem_a`, `mem_wn`, `idx` all become 0.
  - An in-flight store is aborted; bytes already retired stay written and the remaining bytes are never issued.
  - `req` is ignored on the reset edge.

## Timing
Reset values: all outputs 0, state IDLE.

Accept-to-first-byte: `req` sampled at edge 0 puts byte 0 on the bus in cycle 1, i.e. between edges 0 and 1.

With `gnt` held at 1:
- Byte store: bus cycle 1, `done` in cycle 2.
- Half store: bus cycles 1–2, `done` in cycle 3.
- Word store: bus cycles 1–4, `done` in cycle 5.
- `busy`=1 exactly for the bus cycles.

Grant effects:
- Each cycle with `gnt`=0 during WRITE adds one cycle, with the bus contents unchanged.
- `gnt` has no effect outside WRITE.

Back-to-back stores: `req` in the DONE cycle starts the next store's byte 0 in the following cycle. The engine sustains one idle-free gap: a `done` cycle between stores.

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with `req`=1 → `busy`=`done`=`mem_wr`=0, `mem_a`=0. After release, if `req` stays high, a store starts one cycle later.
- **Word store, `gnt`=1:** `addr`=0x100, `data`=0xDDCCBBAA, `size`=2 → cycles 1–4 carry (0x100,0xAA), (0x101,0xBB), (0x102,0xCC), (0x103,0xDD) with `mem_wr`=1; `done`=1 only in cycle 5; `busy` is high in cycles 1–4.
- **Byte and half stores:** `size`=0, `addr`=0x7, `data`=0x12345678 → one write (0x7,0x78), `done` in cycle 2. `size`=1, `addr`=0x21 → writes (0x21,0x78), (0x22,0x56), `done` in cycle 3.
- **Grant stall and wrap:** word store at `addr`=0xFFFFFFFE with `gnt` low in cycles 2–3 → addresses FFFFFFFE, FFFFFFFF (held for 3 cycles), 0x0, 0x1; `done` in cycle 7; no write is counted while `gnt`=0.
- **Back-to-back stores and ignored `req`:** pulse `req` again in cycle 2 of a word store → that request is ignored. Assert `req` in the DONE cycle with `size`=0, `addr`=0x40 → (0x40, byte) is on the bus in the next cycle.
- **Reset mid-operation:** assert `rst` in cycle 2 of a word store → only bytes 0–1 are written; from the next cycle `mem_wr`=0 and `busy`=0, and no `done` pulse occurs.
